// File: rtl/ext_pkg.sv
// rtl/ext_pkg.sv - extension mode encodings and legality helper
package ext_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_ZERO  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SIGN  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_UPPER = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SHAMT = 3'd3;

    function automatic logic is_legal_mode(input logic [MODE_W-1:0] mode);
        return (mode <= MODE_SHAMT);
    endfunction

endpackage

// File: rtl/ext_comb.sv
// rtl/ext_comb.sv - combinational zero/sign/upper/shamt field extender
module ext_comb
    import ext_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [IN_W-1:0]   in_data,
    input  logic [MODE_W-1:0] in_mode,
    output logic [OUT_W-1:0]  data,
    output logic              err
);

    always_comb begin
        data = '0;
        err  = !is_legal_mode(in_mode);
        case (in_mode)
            MODE_ZERO:  data = {{(OUT_W-IN_W){1'b0}}, in_data};
            MODE_SIGN:  data = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
            MODE_UPPER: data = {in_data, {(OUT_W-IN_W){1'b0}}};
            MODE_SHAMT: data = {{(OUT_W-SHAMT_W){1'b0}}, in_data[SHAMT_W-1:0]};
            default:    data = '0;
        endcase
    end

endmodule

// File: rtl/ext_unit_pipe.sv
// rtl/ext_unit_pipe.sv - pipelined extension unit with main/skid output buffering
module ext_unit_pipe
    import ext_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt
);

    logic [OUT_W-1:0] comb_data;
    logic             comb_err;

    logic             main_valid;
    logic [OUT_W-1:0] main_data;
    logic             main_err;
    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;
    logic             skid_err;

    logic accept;
    logic drain;

    ext_comb #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHAMT_W (SHAMT_W)
    ) u_ext_comb (
        .in_data (in_data),
        .in_mode (in_mode),
        .data    (comb_data),
        .err     (comb_err)
    );

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally
    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready;
    assign drain     = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_err   = main_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
        end else if (drain) begin
            // skid full implies in_ready was low, so no accept can collide here
            if (skid_valid) begin
                main_data  <= skid_data;
                main_err   <= skid_err;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data <= comb_data;
                main_err  <= comb_err;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_valid <= 1'b1;
                main_data  <= comb_data;
                main_err   <= comb_err;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= comb_data;
                skid_err   <= comb_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (accept && comb_err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// tb/tb_ext_unit_pipe.sv - directed self-checking bench for ext_unit_pipe
module tb_ext_unit_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic [7:0]  err_cnt;

    int n_vec;
    int n_err;

    ext_unit_pipe #(
        .IN_W    (16),
        .OUT_W   (32),
        .SHAMT_W (5),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] d);
        in_valid = v;
        in_mode  = m;
        in_data  = d;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 16'h0000);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // basic modes, one beat per cycle
        drive(1'b1, 3'd1, 16'hFFDB);
        @(negedge clk);
        chk("sign_neg_valid", 32'(out_valid), 32'd1);
        chk("sign_neg_data",  out_data,       32'hFFFFFFDB);
        chk("sign_neg_err",   32'(out_err),   32'd0);
        drive(1'b1, 3'd1, 16'h0025);
        @(negedge clk);
        chk("sign_pos_data", out_data, 32'h00000025);
        drive(1'b1, 3'd0, 16'hFFB3);
        @(negedge clk);
        chk("zero_data", out_data, 32'h0000FFB3);
        drive(1'b1, 3'd3, 16'hFFF9);
        @(negedge clk);
        chk("shamt_data", out_data, 32'h00000019);
        drive(1'b1, 3'd2, 16'h1234);
        @(negedge clk);
        chk("upper_data", out_data, 32'h12340000);
        drive(1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        chk("idle_valid", 32'(out_valid), 32'd0);

        // backpressure: A, B accepted, C held
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h000A);
        @(negedge clk);
        chk("bp_a_data",   out_data,       32'h0000000A);
        chk("bp_a_ready",  32'(in_ready),  32'd1);
        drive(1'b1, 3'd0, 16'h000B);
        @(negedge clk);
        chk("bp_b_ready",  32'(in_ready),  32'd0);
        chk("bp_b_hold",   out_data,       32'h0000000A);
        drive(1'b1, 3'd0, 16'h000C);
        @(negedge clk);
        chk("bp_c_ready",  32'(in_ready),  32'd0);
        chk("bp_c_hold",   out_data,       32'h0000000A);
        chk("bp_c_valid",  32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_out_b",       out_data,      32'h0000000B);
        chk("bp_ready_back",  32'(in_ready), 32'd1);
        @(negedge clk);
        chk("bp_out_c",       out_data,       32'h0000000C);
        chk("bp_out_c_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        chk("bp_empty", 32'(out_valid), 32'd0);

        // back-to-back stream of 8 beats
        drive(1'b1, 3'd0, 16'h0100);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_data",  out_data,       32'h00000100 + 32'(i - 1));
            if (i < 8) drive(1'b1, 3'd0, 16'h0100 + 16'(i));
            else       drive(1'b0, 3'd0, 16'h0000);
        end
        @(negedge clk);
        chk("b2b_end", 32'(out_valid), 32'd0);

        // illegal mode and counter saturation
        drive(1'b1, 3'd5, 16'hABCD);
        @(negedge clk);
        chk("ill_data", out_data,      32'd0);
        chk("ill_err",  32'(out_err),  32'd1);
        chk("ill_cnt",  32'(err_cnt),  32'd1);
        drive(1'b1, 3'd7, 16'h5555);
        repeat (299) @(negedge clk);
        drive(1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        chk("ill_sat", 32'(err_cnt), 32'd255);
        drive(1'b1, 3'd1, 16'h8000);
        @(negedge clk);
        chk("legal_err_clear", 32'(out_err), 32'd0);
        chk("legal_data",      out_data,     32'hFFFF8000);
        chk("legal_cnt_hold",  32'(err_cnt), 32'd255);

        // async reset with main and skid both occupied
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h0011);
        @(negedge clk);
        drive(1'b1, 3'd0, 16'h0022);
        @(negedge clk);
        chk("pre_rst_ready", 32'(in_ready), 32'd0);
        drive(1'b0, 3'd0, 16'h0000);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt",   32'(err_cnt),   32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_data",  out_data,       32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(out_valid), 32'd0);
        drive(1'b1, 3'd2, 16'hBEEF);
        @(negedge clk);
        chk("post_rst_data", out_data, 32'hBEEF0000);
        drive(1'b0, 3'd0, 16'h0000);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
